// File: rtl/jtoutrun_ba_pkg.sv
// jtoutrun_ba_pkg: shared types for the 4-bank SDRAM responder.
package jtoutrun_ba_pkg;
    localparam int BANKS = 4;
    localparam int BA_AW = 22;
    typedef enum logic [1:0] {IDLE, RD, WR, RFSH} state_t;
    typedef struct packed {
        logic       valid;
        logic [1:0] bank;
        logic       last;
        logic       first;
    } tag_t;
    function automatic logic [BANKS-1:0] onehot(input logic [1:0] b);
        return BANKS'(1) << b;
    endfunction
endpackage

// File: rtl/jtoutrun_bank_resp_if.sv
// jtoutrun_bank_resp_if: bank request/response bus plus the memory port it is served from.
interface jtoutrun_bank_resp_if;
    import jtoutrun_ba_pkg::*;
    logic [BA_AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
    logic [BANKS-1:0] ba_rd;
    logic             ba_wr;
    logic [15:0]      ba0_din;
    logic [1:0]       ba0_din_m;
    logic [BANKS-1:0] ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [15:0]      data_read;
    logic [23:0]      mem_addr;
    logic             mem_rd, mem_wr;
    logic [1:0]       mem_wmask;
    logic [15:0]      mem_din, mem_dout;
    modport master(
        output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, ba_wr, ba0_din, ba0_din_m, mem_dout,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd, mem_wr, mem_wmask, mem_din
    );
    modport slave(
        input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd, ba_wr, ba0_din, ba0_din_m, mem_dout,
        output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, mem_addr, mem_rd, mem_wr, mem_wmask, mem_din
    );
endinterface

// File: rtl/jtoutrun_rr_arb.sv
// jtoutrun_rr_arb: 4-way round-robin arbiter; search starts at the pointer and wraps.
module jtoutrun_rr_arb
    import jtoutrun_ba_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [BANKS-1:0] req,
    input  logic             take,
    output logic [1:0]       win,
    output logic             valid
);
    logic [1:0] ptr;
    always_comb begin
        win   = ptr;
        valid = 1'b0;
        for (int i = 0; i < BANKS; i++) begin
            if (!valid && req[ptr + 2'(i)]) begin
                win   = ptr + 2'(i);
                valid = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (take) ptr <= win + 2'd1;
    end
endmodule

// File: rtl/jtoutrun_bank_resp.sv
// jtoutrun_bank_resp: serves four bank requesters as fixed-length bursts on a
// single fixed-latency memory port, with optional periodic refresh slots.
module jtoutrun_bank_resp
    import jtoutrun_ba_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int BURST       = 2,
    parameter int RFSH_PERIOD = 0,
    parameter int RFSH_LEN    = 4
)(
    input logic clk,
    input logic rst,
    jtoutrun_bank_resp_if.slave bus
);
    state_t           state;
    logic [1:0]       win, rd_bank;
    logic             valid, take, pend, expire, rd_first, rd_last;
    logic [2:0]       cnt;
    logic [7:0]       rcnt;
    logic [BA_AW-1:0] sel_addr;
    tag_t             pipe [LATENCY];
    tag_t             tail;

    assign take = state == IDLE && !pend && valid;
    assign tail = pipe[LATENCY-1];
    always_comb sel_addr = win == 2'd0 ? bus.ba0_addr : win == 2'd1 ? bus.ba1_addr :
                           win == 2'd2 ? bus.ba2_addr : bus.ba3_addr;

    jtoutrun_rr_arb u_arb(.clk(clk), .rst(rst), .req(bus.ba_rd), .take(take), .win(win), .valid(valid));

    generate
        if (RFSH_PERIOD > 0) begin : g_rfsh
            logic [15:0] rfsh_cnt;
            assign expire = rfsh_cnt == 16'(RFSH_PERIOD - 1);
            always_ff @(posedge clk) rfsh_cnt <= rst || expire ? '0 : rfsh_cnt + 16'd1;
        end else begin : g_no_rfsh
            assign expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pend          <= 1'b0;
            cnt           <= '0;
            rcnt          <= '0;
            rd_bank       <= '0;
            rd_first      <= 1'b0;
            rd_last       <= 1'b0;
            bus.ba_ack    <= '0;
            bus.ba_dst    <= '0;
            bus.ba_dok    <= '0;
            bus.ba_rdy    <= '0;
            bus.data_read <= '0;
            bus.mem_addr  <= '0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_wmask <= '0;
            bus.mem_din   <= '0;
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pend       <= expire || (pend && state != IDLE);
            bus.ba_ack <= '0;
            bus.mem_wr <= 1'b0;
            // tags ride alongside mem_rd so each returning word knows its bank and position
            pipe[0] <= {bus.mem_rd, rd_bank, rd_last, rd_first};
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
            bus.ba_dok <= tail.valid ? onehot(tail.bank) : '0;
            bus.ba_dst <= tail.valid && tail.first ? onehot(tail.bank) : '0;
            bus.ba_rdy <= tail.valid && tail.last ? onehot(tail.bank) : '0;
            if (tail.valid) bus.data_read <= bus.mem_dout;
            case (state)
                IDLE: begin
                    if (pend) begin
                        state <= RFSH;
                        rcnt  <= '0;
                    end else if (valid) begin
                        bus.ba_ack   <= onehot(win);
                        bus.mem_addr <= {win, sel_addr};
                        if (win == 2'd0 && bus.ba_wr) begin
                            state         <= WR;
                            bus.mem_wr    <= 1'b1;
                            bus.mem_din   <= bus.ba0_din;
                            bus.mem_wmask <= ~bus.ba0_din_m;
                        end else begin
                            state      <= RD;
                            bus.mem_rd <= 1'b1;
                            rd_bank    <= win;
                            rd_first   <= 1'b1;
                            rd_last    <= BURST == 1;
                            cnt        <= 3'd1;
                        end
                    end
                end
                RD: begin
                    if (bus.mem_rd) begin
                        bus.mem_rd              <= !rd_last;
                        bus.mem_addr[BA_AW-1:0] <= bus.mem_addr[BA_AW-1:0] + BA_AW'(1);
                        rd_first                <= 1'b0;
                        rd_last                 <= cnt == 3'(BURST - 1);
                        cnt                     <= cnt + 3'd1;
                    end
                    if (|bus.ba_rdy) state <= IDLE;
                end
                WR: begin
                    if (|bus.ba_rdy) state <= IDLE;
                    else bus.ba_rdy <= 4'b0001;
                end
                RFSH: begin
                    if (rcnt == 8'(RFSH_LEN - 1)) state <= IDLE;
                    else rcnt <= rcnt + 8'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtoutrun_bank_resp.sv
// tb_jtoutrun_bank_resp: directed checks of reads, writes, arbitration, reset and refresh.
module tb_jtoutrun_bank_resp;
    logic clk = 1'b0, rst = 1'b1, rst_b = 1'b1;
    always #5 clk = ~clk;

    jtoutrun_bank_resp_if a();
    jtoutrun_bank_resp_if b();
    jtoutrun_bank_resp u_dut(.clk(clk), .rst(rst), .bus(a.slave));
    jtoutrun_bank_resp #(.RFSH_PERIOD(20)) u_rfsh(.clk(clk), .rst(rst_b), .bus(b.slave));

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // memory with a two-cycle read pipe; pokes preload it without touching the DUT
    logic [15:0] mem [1024];
    logic [23:0] rp [2];
    logic        poke_en = 1'b0;
    logic [23:0] poke_a = '0;
    logic [15:0] poke_d = '0;
    function automatic logic [9:0] mi(input logic [23:0] ad);
        return {ad[23:22], ad[7:0]};
    endfunction
    always @(posedge clk) begin
        rp[0] <= a.mem_addr;
        rp[1] <= rp[0];
        if (poke_en) mem[mi(poke_a)] <= poke_d;
        if (a.mem_wr && a.mem_wmask[0]) mem[mi(a.mem_addr)][7:0] <= a.mem_din[7:0];
        if (a.mem_wr && a.mem_wmask[1]) mem[mi(a.mem_addr)][15:8] <= a.mem_din[15:8];
    end
    assign a.mem_dout = mem[mi(rp[1])];
    assign b.mem_dout = 16'h0;

    task automatic poke(input logic [23:0] ad, input logic [15:0] d);
        poke_a = ad; poke_d = d; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    logic [3:0]  h_ack [8], h_dst [8], h_dok [8], h_rdy [8];
    logic [15:0] h_dr [8], h_din [8];
    logic [23:0] h_ma [8];
    logic        h_rd [8], h_wr [8];
    logic [1:0]  h_wm [8];
    task automatic grab(input int n);
        h_ack[n] = a.ba_ack; h_dst[n] = a.ba_dst; h_dok[n] = a.ba_dok; h_rdy[n] = a.ba_rdy;
        h_dr[n] = a.data_read; h_din[n] = a.mem_din; h_ma[n] = a.mem_addr;
        h_rd[n] = a.mem_rd; h_wr[n] = a.mem_wr; h_wm[n] = a.mem_wmask;
    endtask

    // raise a request, wait for its ack, drop it, record eight cycles from the ack cycle
    task automatic access(input logic [3:0] req, input logic wr);
        int i;
        a.ba_rd = req; a.ba_wr = wr; i = 0;
        do begin @(negedge clk); i++; end while (a.ba_ack == 4'h0 && i < 20);
        check("ack_seen", 32'(a.ba_ack != 4'h0), 32'd1);
        a.ba_rd = 4'h0; a.ba_wr = 1'b0;
        grab(0);
        for (int n = 1; n < 8; n++) begin @(negedge clk); grab(n); end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'({a.ba_ack, a.ba_dst, a.ba_dok, a.ba_rdy, a.mem_rd, a.mem_wr, a.mem_wmask}), 32'd0);
        check({tag, "_dat"}, {a.data_read, a.mem_din}, 32'd0);
        check({tag, "_adr"}, 32'(a.mem_addr), 32'd0);
    endtask

    initial begin
        int i, na, nr, last, n11, nbad, nbrk, nack, since;
        logic [3:0] dirty;
        int ack_t [8], rdy_t [8];
        logic [3:0] ack_b [8];
        a.ba0_addr = '0; a.ba1_addr = '0; a.ba2_addr = '0; a.ba3_addr = '0;
        a.ba_rd = '0; a.ba_wr = 1'b0; a.ba0_din = '0; a.ba0_din_m = '0;
        b.ba0_addr = '0; b.ba1_addr = '0; b.ba2_addr = '0; b.ba3_addr = '0;
        b.ba_rd = '0; b.ba_wr = 1'b0; b.ba0_din = '0; b.ba0_din_m = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        poke({2'd1, 22'h100}, 16'h1234);
        poke({2'd1, 22'h101}, 16'h5678);
        a.ba1_addr = 22'h100;
        access(4'b0010, 1'b0);
        check("rd_ack", 32'(h_ack[0]), 32'h2);
        check("rd_strobe", 32'({h_rd[0], h_rd[1], h_rd[2]}), 32'b110);
        check("rd_addr0", 32'(h_ma[0]), 32'h400100);
        check("rd_addr1", 32'(h_ma[1]), 32'h400101);
        check("rd_dst", 32'({h_dst[2], h_dst[3], h_dst[4]}), 32'h020);
        check("rd_dok", 32'({h_dok[2], h_dok[3], h_dok[4], h_dok[5]}), 32'h0220);
        check("rd_rdy", 32'({h_rdy[3], h_rdy[4], h_rdy[5]}), 32'h020);
        check("rd_word0", 32'(h_dr[3]), 32'h1234);
        check("rd_word1", 32'(h_dr[4]), 32'h5678);
        check("rd_hold", 32'(h_dr[6]), 32'h5678);

        poke({2'd0, 22'h5}, 16'hFFFF);
        a.ba0_addr = 22'h5; a.ba0_din = 16'hABCD; a.ba0_din_m = 2'b10;
        access(4'b0001, 1'b1);
        check("wr_ack", 32'(h_ack[0]), 32'h1);
        check("wr_strobe", 32'({h_wr[0], h_wr[1], h_rd[0]}), 32'b100);
        check("wr_mask", 32'(h_wm[0]), 32'b01);
        check("wr_data", 32'(h_din[0]), 32'hABCD);
        check("wr_addr", 32'(h_ma[0]), 32'h000005);
        check("wr_rdy", 32'({h_rdy[0], h_rdy[1], h_rdy[2]}), 32'h010);
        check("wr_nodok", 32'(h_dok[0] | h_dok[1] | h_dok[2] | h_dst[0] | h_dst[1] | h_dst[2]), 32'h0);
        access(4'b0001, 1'b0);
        check("wr_readback", 32'(h_dr[3]), 32'hFFCD);

        // reset in the middle of a bank 2 burst; pointer is non-zero beforehand
        a.ba2_addr = 22'h7; a.ba_rd = 4'b0100; i = 0;
        do begin @(negedge clk); i++; end while (a.ba_ack == 4'h0 && i < 20);
        check("pre_rst_ack", 32'(a.ba_ack), 32'h4);
        rst = 1'b1; a.ba_rd = 4'h0;
        @(negedge clk);
        check_zero("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dirty = '0;
        repeat (6) begin @(negedge clk); dirty |= a.ba_dok | a.ba_rdy | a.ba_dst; end
        check("rst_no_stray", 32'(dirty), 32'h0);

        a.ba_rd = 4'b1111; na = 0; nr = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (a.ba_ack != 4'h0 && na < 8) begin ack_t[na] = c; ack_b[na] = a.ba_ack; na++; end
            if (a.ba_rdy != 4'h0 && nr < 8) begin rdy_t[nr] = c; nr++; end
        end
        a.ba_rd = 4'h0;
        check("rr_count", 32'(na >= 5), 32'd1);
        for (int k = 0; k < 5; k++) check("rr_bank", 32'(ack_b[k]), 32'(4'b0001 << (k % 4)));
        for (int k = 0; k < 4; k++) begin
            check("rr_period", 32'(ack_t[k+1] - ack_t[k]), 32'd6);
            check("rr_rdy2ack", 32'(ack_t[k+1] - rdy_t[k]), 32'd2);
        end
        repeat (10) @(negedge clk);

        a.ba3_addr = 22'h3FFFFF;
        access(4'b1000, 1'b0);
        check("wrap_ack", 32'(h_ack[0]), 32'h8);
        check("wrap_addr0", 32'(h_ma[0]), 32'hFFFFFF);
        check("wrap_addr1", 32'(h_ma[1]), 32'hC00000);

        // refresh: gaps between bank 2 acks are 6 normally, 11 when a refresh slot intervenes
        b.ba_rd = 4'b0100; rst_b = 1'b0;
        last = -1; n11 = 0; nbad = 0; nbrk = 0; nack = 0; since = 99;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            since++;
            if (since == 1 && !b.mem_rd) nbrk++;
            if (since == 2 && b.mem_rd) nbrk++;
            if (b.ba_ack != 4'h0) begin
                nack++;
                if (b.ba_ack != 4'b0100 || !b.mem_rd) nbrk++;
                if (last >= 0) begin
                    if (c - last == 11) n11++;
                    else if (c - last != 6) nbad++;
                end
                last = c; since = 0;
            end
        end
        check("rfsh_acks", 32'(nack >= 40), 32'd1);
        check("rfsh_gaps", 32'(nbad), 32'd0);
        check("rfsh_bursts", 32'(nbrk), 32'd0);
        check("rfsh_slots", 32'(n11 >= 18 && n11 <= 20), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
